instr_encoder: RTL and testbench

- Converts a stream of symbolic RV32I instruction commands (kind, funct3, funct7b5, rd, rs1, rs2, immediate) into 32-bit machine words.
- Its field placement is the exact inverse of the processor's op/funct3/funct7b5/ImmSrc decode.
- Words are buffered in a small FIFO with valid/ready handshakes on both sides, and each emitted word is tagged with a running byte address.
- Used by the bench and boot path to feed instruction memory with encodings the single-cycle core decodes.

---
 rtl/instr_encoder.sv | 155 +++++++++++++++
 tb/tb_instr_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I command-to-machine-word encoder feeding a small FIFO; each popped word carries a running byte address.
// Optional immediate validation is enabled by defining INSTR_ENCODER_IMM_CHECK_EN.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_kind,
    input  logic [2:0]                 cmd_funct3,
    input  logic                       cmd_funct7b5,
    input  logic [4:0]                 cmd_rd,
    input  logic [4:0]                 cmd_rs1,
    input  logic [4:0]                 cmd_rs2,
    input  logic [20:0]                cmd_imm,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr_word,
    output logic [31:0]                instr_addr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;

    logic [31:0] word_enc;
    logic [6:0]  f7;
    logic        bad_cmd;
    logic        is_shift;
    logic        accept, push, pop;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    logic fits12, fits13;
    assign fits12 = (&cmd_imm[20:11]) | ~(|cmd_imm[20:11]);
    assign fits13 = (&cmd_imm[20:12]) | ~(|cmd_imm[20:12]);
`else
    logic unused_imm_lsb;
    assign unused_imm_lsb = cmd_imm[0];
`endif

    always_comb begin
        word_enc = '0;
        bad_cmd  = 1'b0;
        f7       = 7'b0;
        is_shift = (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101);
        case (cmd_kind)
            3'd0: begin
                if (cmd_funct7b5 && (cmd_funct3 == 3'b000 || cmd_funct3 == 3'b101))
                    f7 = 7'b0100000;
                word_enc = {f7, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, 7'b0110011};
            end
            3'd1: begin
                // Shifts carry shamt in imm[4:0]; bit 30 selects arithmetic right shift.
                if (is_shift)
                    word_enc = {1'b0, cmd_funct7b5 && (cmd_funct3 == 3'b101), 5'b0,
                                cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
                else
                    word_enc = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                bad_cmd = !fits12 || (is_shift && (cmd_imm[11:5] != 7'b0));
`endif
            end
            3'd2: begin
                word_enc = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, 7'b0000011};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                bad_cmd = !fits12;
`endif
            end
            3'd3: begin
                word_enc = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                bad_cmd = !fits12;
`endif
            end
            3'd4: begin
                word_enc = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, 3'b000,
                            cmd_imm[4:1], cmd_imm[11], 7'b1100011};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                bad_cmd = !fits13 || cmd_imm[0];
`endif
            end
            3'd5: begin
                word_enc = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                            cmd_rd, 7'b1101111};
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                bad_cmd = cmd_imm[0];
`endif
            end
            default: bad_cmd = 1'b1;
        endcase
    end

    assign cmd_ready   = (count_q != LW'(DEPTH));
    assign instr_valid = (count_q != '0);
    assign instr_word  = instr_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign instr_addr  = addr_q;
    assign level       = count_q;
    assign err_sticky  = err_q;

    // Rejected commands are still handshaken so the producer never stalls on them.
    assign accept = cmd_valid && cmd_ready;
    assign push   = accept && !bad_cmd;
    assign pop    = instr_valid && instr_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q | (accept && bad_cmd);
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + 32'd4;
        end
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // Storage has no reset; the occupancy count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem_q[wr_ptr_q] <= word_enc;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO full/stall, address tagging, reset and error flag.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_kind;
    logic [2:0]  cmd_funct3;
    logic        cmd_funct7b5;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [20:0] cmd_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] instr_addr;
    logic [2:0]  level;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_funct3(cmd_funct3), .cmd_funct7b5(cmd_funct7b5),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .instr_addr(instr_addr),
        .level(level), .err_sticky(err_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] k, input logic [2:0] f3, input logic f7b5,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [20:0] imm);
        cmd_kind = k; cmd_funct3 = f3; cmd_funct7b5 = f7b5;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    endtask

    task automatic push1(input logic [2:0] k, input logic [2:0] f3, input logic f7b5,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [20:0] imm);
        set_cmd(k, f3, f7b5, rd, rs1, rs2, imm);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        $display("push kind=%0d level=%0d err=%0b", k, level, err_sticky);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp_word, input logic [31:0] exp_addr);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_word"}, instr_word, exp_word);
        chk({tag, "_addr"}, instr_addr, exp_addr);
        $display("pop %s word=%h addr=%h", tag, instr_word, instr_addr);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; instr_ready = 1'b0;
        set_cmd(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 21'd0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_word", instr_word, 32'h0);
        chk("rst_addr", instr_addr, 32'h0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // addi x1,x0,5: visible the cycle after acceptance
        push1(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5);
        pop_chk("addi", 32'h0050_0093, 32'h0000_0000);
        chk("addi_empty", 32'(instr_valid), 32'd0);

        // add / sub back to back
        push1(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0);
        push1(3'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0);
        chk("addsub_level", 32'(level), 32'd2);
        pop_chk("add", 32'h0020_81B3, 32'h0000_0004);
        pop_chk("sub", 32'h4020_81B3, 32'h0000_0008);

        // lw x6,-4(x9); sw x6,8(x9); beq x4,x4,+8
        push1(3'd2, 3'b000, 1'b0, 5'd6, 5'd9, 5'd0, -21'sd4);
        push1(3'd3, 3'b000, 1'b0, 5'd0, 5'd9, 5'd6, 21'd8);
        push1(3'd4, 3'b000, 1'b0, 5'd0, 5'd4, 5'd4, 21'd8);
        pop_chk("lw", 32'hFFC4_A303, 32'h0000_000C);
        pop_chk("sw", 32'h0064_A423, 32'h0000_0010);
        pop_chk("beq", 32'h0042_0463, 32'h0000_0014);

        // jal x1,+16; srai x5,x5,3
        push1(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd16);
        push1(3'd1, 3'b101, 1'b1, 5'd5, 5'd5, 5'd0, 21'd3);
        pop_chk("jal", 32'h0100_00EF, 32'h0000_0018);
        pop_chk("srai", 32'h4032_D293, 32'h0000_001C);

        // Fill with consumer stalled; fifth command must wait
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'(10 + i));
            tick();
            $display("fill %0d level=%0d cmd_ready=%0b", i, level, cmd_ready);
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        set_cmd(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd14);
        tick();
        chk("stall_level", 32'(level), 32'd4);
        chk("stall_head", instr_word, 32'h00A0_0093);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("popfull_level", 32'(level), 32'd3);
        chk("popfull_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("fifth_level", 32'(level), 32'd4);
        pop_chk("fill11", 32'h00B0_0093, 32'h0000_0024);
        pop_chk("fill12", 32'h00C0_0093, 32'h0000_0028);
        pop_chk("fill13", 32'h00D0_0093, 32'h0000_002C);
        pop_chk("fill14", 32'h00E0_0093, 32'h0000_0030);
        chk("drain_valid", 32'(instr_valid), 32'd0);

        // Reset mid-stream with a command presented
        push1(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd1);
        push1(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd2);
        push1(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd3);
        chk("pre_rst_level", 32'(level), 32'd3);
        set_cmd(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd9);
        reset = 1'b1; cmd_valid = 1'b1;
        tick();
        reset = 1'b0; cmd_valid = 1'b0;
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_addr", instr_addr, 32'h0);
        tick();
        chk("mrst_level2", 32'(level), 32'd0);

        // Out-of-range addi immediate, then reserved kind
        push1(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd2048);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
        chk("imm_err", 32'(err_sticky), 32'd1);
        chk("imm_level", 32'(level), 32'd0);
`else
        chk("imm_err", 32'(err_sticky), 32'd0);
        pop_chk("imm_trunc", 32'h8000_0093, 32'h0000_0000);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_clear", 32'(err_sticky), 32'd0);
        push1(3'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd0);
        chk("k7_err", 32'(err_sticky), 32'd1);
        chk("k7_level", 32'(level), 32'd0);
        push1(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5);
        chk("err_sticks", 32'(err_sticky), 32'd1);
        pop_chk("post_err", 32'h0050_0093, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
